// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared state encoding and mode constants for the serial pattern generator
package seq_gen_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;
endpackage

// File: rtl/seq_idx_counter.sv
// seq_idx_counter: up/down pattern index with load-to-first, advance, wrap and last-index flag
module seq_idx_counter #(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    input  logic             down,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] idx_nxt,
    output logic             last
);
    logic [LEN_W-1:0] idx, top, first;
    always_comb begin
        top     = len - LEN_W'(1);
        first   = down ? top : '0;
        last    = down ? (idx == '0) : (idx == top);
        idx_nxt = load ? first : !adv ? idx : last ? first : down ? idx - LEN_W'(1) : idx + LEN_W'(1);
    end
    always_ff @(posedge clk) idx <= rst ? '0 : idx_nxt;
endmodule

// File: rtl/seq_pattern_generator.sv
// seq_pattern_generator: programmable serial bit-pattern streamer over valid/ready
import seq_gen_pkg::*;
module seq_pattern_generator #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_mode,
    input  logic               cfg_msb_first,
    input  logic               start,
    input  logic               stop,
    input  logic               out_ready,
    output logic               out_data,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    state_t state, state_nxt;
    logic [MAX_LEN-1:0] pattern, n_pattern;
    logic [LEN_W-1:0] len, n_len, idx_nxt;
    logic mode, msb_first, n_mode, n_msb, n_err, legal, ld, go, acc, last, fin, sel_bit;
    seq_idx_counter #(.LEN_W(LEN_W)) u_idx (
        .clk(clk), .rst(rst), .load(go), .adv(acc), .down(n_msb), .len(n_len),
        .idx_nxt(idx_nxt), .last(last)
    );
    // a load in the same cycle as start is resolved first, so n_* feed the run
    always_comb begin
        legal     = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
        ld        = cfg_load && state == IDLE;
        n_pattern = ld && legal ? cfg_pattern : pattern;
        n_len     = ld && legal ? cfg_len : len;
        n_mode    = ld && legal ? cfg_mode : mode;
        n_msb     = ld && legal ? cfg_msb_first : msb_first;
        n_err     = ld ? !legal : cfg_err;
        go        = state == IDLE && start && !n_err;
        acc       = state == RUN && out_ready;
        fin       = acc && last && mode == MODE_ONESHOT && !stop;
        state_nxt = state == IDLE ? (go ? RUN : IDLE) : (stop || fin ? IDLE : RUN);
        sel_bit   = |((n_pattern >> idx_nxt) & MAX_LEN'(1));
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= '0;
            len       <= LEN_W'(1);
            mode      <= MODE_CONT;
            msb_first <= 1'b0;
            cfg_err   <= 1'b0;
            out_data  <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            pattern   <= n_pattern;
            len       <= n_len;
            mode      <= n_mode;
            msb_first <= n_msb;
            cfg_err   <= n_err;
            out_data  <= state_nxt == RUN && sel_bit;
            out_valid <= state_nxt == RUN;
            done      <= fin;
        end
    end
    assign busy = state == RUN;
endmodule
